// File: rtl/quant_seq_ctrl.sv
// quant_seq_ctrl: tile sequencer for the FP32 pre-quantization stage.
// Buffers one tile of activations while tracking the largest magnitude,
// then replays the tile one element per cycle with the tile max alongside.
module quant_seq_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_act_valid,
    input  logic [31:0]      i_act_data,
    output logic             o_act_ready,
    output logic [31:0]      o_pre_max,
    output logic [31:0]      o_pre_activation,
    output logic             o_pre_valid,
    output logic             o_pre_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic [31:0]      max_reg;
    logic [31:0]      mem [DEPTH];

    logic             feed_q;
    logic             last_q;

    logic             start_ok;
    logic             accept;
    logic             issue;
    logic             last_issue;
    logic             load_last;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        accept     = 1'b0;
        load_last  = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE: begin
                // A zero-length start is dropped without leaving IDLE.
                if (i_start && (i_len != '0)) begin
                    start_ok   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (i_act_valid) begin
                    accept = 1'b1;
                    if (wr_cnt == len - ONE) begin
                        load_last  = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                issue = 1'b1;
                if (rd_cnt == len - ONE) begin
                    last_issue = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_act_ready = (state == LOAD);
    assign o_busy      = (state != IDLE);

    // Tile length, write/read pointers and running magnitude maximum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len     <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            max_reg <= '0;
        end else begin
            if (start_ok) begin
                len     <= (i_len > DEPTH_LEN) ? DEPTH_LEN : i_len;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                max_reg <= '0;
            end
            if (accept) begin
                wr_cnt <= wr_cnt + ONE;
                // Sign is ignored: the max is a pure magnitude, stored positive.
                if (i_act_data[30:0] > max_reg[30:0]) begin
                    max_reg <= {1'b0, i_act_data[30:0]};
                end
                if (load_last) begin
                    rd_cnt <= '0;
                end
            end
            if (issue) begin
                rd_cnt <= rd_cnt + ONE;
            end
        end
    end

    // Tile buffer; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt[AW-1:0]] <= i_act_data;
        end
    end

    // Operand registers and strobes; strobes trail the operands by one cycle
    // so they line up with the datapath's registered result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_pre_max        <= '0;
            o_pre_activation <= '0;
            feed_q           <= 1'b0;
            last_q           <= 1'b0;
            o_pre_valid      <= 1'b0;
            o_pre_last       <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            feed_q      <= issue;
            last_q      <= last_issue;
            o_pre_valid <= feed_q;
            o_pre_last  <= last_q;
            o_done      <= last_q;
            if (issue) begin
                o_pre_activation <= mem[rd_cnt[AW-1:0]];
                o_pre_max        <= max_reg;
            end
        end
    end

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Bench for quant_seq_ctrl: table of tiles replayed back to back, plus
// hand sequences for zero length, reset mid-drain and recovery.
module tb_quant_seq_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LEN_W = 7;

    logic             clk;
    logic             reset_n;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_act_valid;
    logic [31:0]      i_act_data;
    logic             o_act_ready;
    logic [31:0]      o_pre_max;
    logic [31:0]      o_pre_activation;
    logic             o_pre_valid;
    logic             o_pre_last;
    logic             o_busy;
    logic             o_done;

    quant_seq_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_start          (i_start),
        .i_len            (i_len),
        .i_act_valid      (i_act_valid),
        .i_act_data       (i_act_data),
        .o_act_ready      (o_act_ready),
        .o_pre_max        (o_pre_max),
        .o_pre_activation (o_pre_activation),
        .o_pre_valid      (o_pre_valid),
        .o_pre_last       (o_pre_last),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [31:0] act;
        logic [31:0] mx;
        logic        last;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        int unsigned len_in;
        int unsigned pat;
        bit          bubbles;
        bit          pulse;
        int unsigned exp_n;
        logic [31:0] exp_max;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Data patterns: 0 = four fixed words, 1 = ramp with alternating sign,
    // 2 = constant 0.5, 3 = constant -1.0.
    function automatic logic [31:0] word(input int unsigned pat, input int unsigned i);
        logic [31:0] w;
        int unsigned ii;
        ii = i;
        case (pat)
            0: begin
                case (ii)
                    0:       w = 32'h3F80_0000;
                    1:       w = 32'h4000_0000;
                    2:       w = 32'hC100_0000;
                    default: w = 32'h3F00_0000;
                endcase
            end
            1:       w = {ii[0], 31'h3F80_0000 + 31'(ii) * 31'h0001_0000};
            2:       w = 32'h3F00_0000;
            default: w = 32'hBF80_0000;
        endcase
        return w;
    endfunction

    // Scoreboard consumer: operands are compared one cycle before the strobe
    // that qualifies them, matching the datapath's register stage.
    logic [31:0] prev_act;
    logic [31:0] prev_max;

    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            sb.delete();
            prev_act = '0;
            prev_max = '0;
        end else begin
            if (o_pre_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("pre_activation", prev_act, e.act);
                    chk("pre_max", prev_max, e.mx);
                    chk("pre_last", 32'(o_pre_last), 32'(e.last));
                    chk("done", 32'(o_done), 32'(e.last));
                end
            end else if (o_pre_last || o_done) begin
                chk("stray_strobe", {30'd0, o_pre_last, o_done}, 32'd0);
            end
            prev_act = o_pre_activation;
            prev_max = o_pre_max;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_max"},   o_pre_max,        32'd0);
        chk({tag, "_act"},   o_pre_activation, 32'd0);
        chk({tag, "_valid"}, 32'(o_pre_valid), 32'd0);
        chk({tag, "_last"},  32'(o_pre_last),  32'd0);
        chk({tag, "_done"},  32'(o_done),      32'd0);
        chk({tag, "_busy"},  32'(o_busy),      32'd0);
        chk({tag, "_ready"}, 32'(o_act_ready), 32'd0);
    endtask

    task automatic start_tile(input int unsigned len_in);
        i_start = 1'b1;
        i_len   = LEN_W'(len_in);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("start_busy",  32'(o_busy),      32'd1);
        chk("start_ready", 32'(o_act_ready), 32'd1);
    endtask

    // Drives words while counting handshakes; ends at the first accept
    // after which ready is low.
    task automatic load_tile(input int unsigned pat, input bit bubbles,
                             input int unsigned exp_n, input logic [31:0] exp_max);
        int unsigned acc;
        bit          hs;
        bit          fin;
        sb_t         e;
        acc = 0;
        fin = 1'b0;
        for (int unsigned c = 0; c < 3 * exp_n + 12 && !fin; c++) begin
            i_act_valid = bubbles ? (c % 3 == 0) : 1'b1;
            i_act_data  = i_act_valid ? word(pat, acc) : $urandom;
            hs = i_act_valid && o_act_ready;
            @(posedge clk); #1;
            if (hs) begin
                e.act  = word(pat, acc);
                e.mx   = exp_max;
                e.last = (acc == exp_n - 1);
                sb.push_back(e);
                acc++;
                if (!o_act_ready) fin = 1'b1;
            end
        end
        i_act_valid = 1'b0;
        chk("accepted_count", 32'(acc), 32'(exp_n));
        chk("load_finished", 32'(fin), 32'd1);
    endtask

    // Measures strobe timing relative to the last accept edge.
    task automatic drain_check(input int unsigned exp_n, input bit pulse);
        int unsigned first_v;
        int unsigned done_at;
        int unsigned nv;
        bit          busy_ok;
        first_v = 0;
        done_at = 0;
        nv      = 0;
        busy_ok = 1'b1;
        if (pulse) begin
            i_start = 1'b1;
            i_len   = LEN_W'(3);
        end
        for (int unsigned c = 1; c <= exp_n + 6; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_pre_valid) begin
                nv++;
                if (first_v == 0) first_v = c;
            end
            if (o_done) begin
                done_at = c;
                break;
            end
            if (!o_busy) busy_ok = 1'b0;
        end
        chk("first_valid_cycle", 32'(first_v), 32'd2);
        chk("done_cycle", 32'(done_at), 32'(exp_n + 1));
        chk("valid_count", 32'(nv), 32'(exp_n));
        chk("busy_through_flush", 32'(busy_ok), 32'd1);
        chk("idle_at_done", 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nv;

        vecs[0] = '{len_in: 4,   pat: 0, bubbles: 1'b0, pulse: 1'b0, exp_n: 4,  exp_max: 32'h4100_0000};
        vecs[1] = '{len_in: 8,   pat: 1, bubbles: 1'b1, pulse: 1'b1, exp_n: 8,  exp_max: 32'h3F87_0000};
        vecs[2] = '{len_in: 100, pat: 1, bubbles: 1'b0, pulse: 1'b0, exp_n: 64, exp_max: 32'h3FBF_0000};
        vecs[3] = '{len_in: 1,   pat: 3, bubbles: 1'b0, pulse: 1'b0, exp_n: 1,  exp_max: 32'h3F80_0000};
        vecs[4] = '{len_in: 3,   pat: 2, bubbles: 1'b0, pulse: 1'b0, exp_n: 3,  exp_max: 32'h3F00_0000};

        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_len       = '0;
        i_act_valid = 1'b0;
        i_act_data  = '0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Zero-length start must be ignored.
        i_start = 1'b1;
        i_len   = '0;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("len0_busy",  32'(o_busy),      32'd0);
        chk("len0_ready", 32'(o_act_ready), 32'd0);
        @(posedge clk); #1;
        chk("len0_busy2", 32'(o_busy), 32'd0);
        chk("len0_done",  32'(o_done), 32'd0);

        // Table tiles run back to back: each start lands in the previous o_done cycle.
        for (int unsigned v = 0; v < 5; v++) begin
            start_tile(vecs[v].len_in);
            load_tile(vecs[v].pat, vecs[v].bubbles, vecs[v].exp_n, vecs[v].exp_max);
            drain_check(vecs[v].exp_n, vecs[v].pulse);
        end

        // Reset after two of five valids aborts the tile.
        start_tile(5);
        load_tile(1, 1'b0, 5, 32'h3F84_0000);
        nv = 0;
        for (int unsigned c = 0; c < 12 && nv < 2; c++) begin
            @(posedge clk); #1;
            if (o_pre_valid) nv++;
        end
        chk("abort_two_valids", 32'(nv), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;
        nv = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (o_done || o_pre_valid || o_busy) nv++;
        end
        chk("abort_quiet", 32'(nv), 32'd0);

        start_tile(2);
        load_tile(1, 1'b0, 2, 32'h3F81_0000);
        drain_check(2, 1'b0);

        @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
